// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: hunts for SYNC_PAT, then collects a DATA_W-bit word MSB-first into a one-entry valid/ready buffer.
// Optional feature macro PARITY_EN adds an even-parity bit after the payload.
module serial_frame_deserializer #(
    parameter logic [3:0] SYNC_PAT = 4'b1011,
    parameter int         DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              locked,
    output logic              overrun,
    output logic              parity_err,
    output logic [7:0]        frame_cnt
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_HUNT,
        S_DATA
`ifdef PARITY_EN
        , S_PARITY
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          window_q, window_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                data_valid_q, data_valid_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                complete;
    logic                accept;
`ifdef PARITY_EN
    logic                parity_fail;
    logic                parity_err_q, parity_err_d;
`endif

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        complete = 1'b0;
`ifdef PARITY_EN
        parity_fail = 1'b0;
`endif
        case (state_q)
            S_HUNT: begin
                window_d = {window_q[1:0], sin};
                // Window is cleared on leaving HUNT, so payload bits can never complete a sync.
                if ({window_q, sin} == SYNC_PAT) begin
                    state_d  = S_DATA;
                    cnt_d    = '0;
                    window_d = '0;
                end
            end
            S_DATA: begin
                word_d = {word_q[DATA_W-2:0], sin};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
`ifdef PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d  = S_HUNT;
                    complete = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                state_d = S_HUNT;
                if (^{word_q, sin}) parity_fail = 1'b1;
                else                complete    = 1'b1;
            end
`endif
            default: state_d = S_HUNT;
        endcase
    end

    // Completion while the buffer is held loses the new frame, not the unconsumed one.
    always_comb begin
        accept       = !data_valid_q || data_ready;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = 1'b0;
        frame_cnt_d  = frame_cnt_q;
`ifdef PARITY_EN
        parity_err_d = parity_fail;
`endif
        if (complete) begin
            if (accept) begin
                data_d       = word_d;
                data_valid_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_HUNT;
            window_q     <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
`ifdef PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
`ifdef PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign locked     = (state_q != S_HUNT);
    assign overrun    = overrun_q;
    assign frame_cnt  = frame_cnt_q;
`ifdef PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed self-checking bench for serial_frame_deserializer (default parameters, both PARITY_EN builds).
module tb_serial_frame_deserializer;

    localparam logic [3:0] SYNC = 4'b1011;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       locked;
    logic       overrun;
    logic       parity_err;
    logic [7:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    serial_frame_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .locked     (locked),
        .overrun    (overrun),
        .parity_err (parity_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Input is applied 1 time unit after an edge; outputs are read at the same point.
    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_payload(input logic [7:0] w, input logic par, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
`ifndef PARITY_EN
            if (i == 0) data_ready = rdy_last;
`endif
            send_bit(w[i]);
        end
`ifdef PARITY_EN
        data_ready = rdy_last;
        send_bit(par);
`else
        if (par === 1'bx) $display("note: parity bit unused");
`endif
    endtask

    task automatic send_frame(input logic [7:0] w, input logic par, input logic rdy_last);
        for (int i = 3; i >= 0; i--) send_bit(SYNC[i]);
        send_payload(w, par, rdy_last);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        send_bit(1'b0);
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        sin        = 1'b0;
        data_ready = 1'b1;
        #1;
        send_bit(1'b0);
        send_bit(1'b0);
        rst = 1'b1;

        check("rst_data",   32'(data), 32'h0);
        check("rst_valid",  32'(data_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_ovr",    32'(overrun), 32'h0);
        check("rst_perr",   32'(parity_err), 32'h0);
        check("rst_cnt",    32'(frame_cnt), 32'h0);

        // Basic frame 8'hA5
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("sync_partial_unlocked", 32'(locked), 32'h0);
        send_bit(1'b1);
        check("sync_locked", 32'(locked), 32'h1);
        send_payload(8'hA5, 1'b0, 1'b1);
        check("a5_data",   32'(data), 32'hA5);
        check("a5_valid",  32'(data_valid), 32'h1);
        check("a5_cnt",    32'(frame_cnt), 32'h1);
        check("a5_locked", 32'(locked), 32'h0);
        send_bit(1'b0);
        check("a5_consumed", 32'(data_valid), 32'h0);
        check("a5_data_held", 32'(data), 32'hA5);

        // Overlapping sync: 1,1,0,1,1 locks on the fifth bit
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("ovl_no_lock4", 32'(locked), 32'h0);
        send_bit(1'b1);
        check("ovl_lock5", 32'(locked), 32'h1);
        send_payload(8'h3C, 1'b0, 1'b1);
        check("3c_data", 32'(data), 32'h3C);
        check("3c_cnt",  32'(frame_cnt), 32'h2);

        // Payload ending in 1011, then idle zeros: no second frame
        send_frame(8'h5B, 1'b1, 1'b1);
        check("5b_data", 32'(data), 32'h5B);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0);
            check("idle_no_lock", 32'(locked), 32'h0);
        end
        check("idle_cnt",   32'(frame_cnt), 32'h3);
        check("idle_valid", 32'(data_valid), 32'h0);

        // Stall: two back-to-back frames with data_ready low
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0);
        check("stall1_data",  32'(data), 32'h11);
        check("stall1_valid", 32'(data_valid), 32'h1);
        check("stall1_ovr",   32'(overrun), 32'h0);
        check("stall1_cnt",   32'(frame_cnt), 32'h4);
        send_frame(8'h22, 1'b0, 1'b0);
        check("stall2_ovr",   32'(overrun), 32'h1);
        check("stall2_data",  32'(data), 32'h11);
        check("stall2_valid", 32'(data_valid), 32'h1);
        check("stall2_cnt",   32'(frame_cnt), 32'h4);
        send_bit(1'b0);
        check("ovr_one_cycle", 32'(overrun), 32'h0);
        check("stall_hold",    32'(data), 32'h11);
        data_ready = 1'b1;
        send_bit(1'b0);
        check("stall_drain", 32'(data_valid), 32'h0);

        // Ready rises on the edge the second frame completes
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0);
        check("race1_cnt", 32'(frame_cnt), 32'h5);
        send_frame(8'h22, 1'b0, 1'b1);
        check("race2_data",  32'(data), 32'h22);
        check("race2_valid", 32'(data_valid), 32'h1);
        check("race2_ovr",   32'(overrun), 32'h0);
        check("race2_cnt",   32'(frame_cnt), 32'h6);
        send_bit(1'b0);

        // Reset after four data bits
        for (int i = 3; i >= 0; i--) send_bit(SYNC[i]);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("mid_locked_pre", 32'(locked), 32'h1);
        do_reset();
        check("mid_locked", 32'(locked), 32'h0);
        check("mid_data",   32'(data), 32'h0);
        check("mid_valid",  32'(data_valid), 32'h0);
        check("mid_cnt",    32'(frame_cnt), 32'h0);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("f0_data",  32'(data), 32'hF0);
        check("f0_valid", 32'(data_valid), 32'h1);
        check("f0_cnt",   32'(frame_cnt), 32'h1);
        send_bit(1'b0);

`ifdef PARITY_EN
        send_frame(8'hA5, 1'b0, 1'b1);
        check("par_ok_data",  32'(data), 32'hA5);
        check("par_ok_valid", 32'(data_valid), 32'h1);
        check("par_ok_perr",  32'(parity_err), 32'h0);
        check("par_ok_cnt",   32'(frame_cnt), 32'h2);
        send_bit(1'b0);
        send_frame(8'hA5, 1'b1, 1'b1);
        check("par_bad_perr",  32'(parity_err), 32'h1);
        check("par_bad_valid", 32'(data_valid), 32'h0);
        check("par_bad_cnt",   32'(frame_cnt), 32'h2);
        send_bit(1'b0);
        check("par_bad_pulse", 32'(parity_err), 32'h0);
`endif

        // Counter wrap over 256 accepted back-to-back frames
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            send_frame(8'(i), ^(8'(i)), 1'b1);
            if (i == 255) check("wrap_255", 32'(frame_cnt), 32'hFF);
        end
        check("wrap_0",    32'(frame_cnt), 32'h0);
        check("wrap_data", 32'(data), 32'h0);
        check("wrap_ovr",  32'(overrun), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
